// File: rtl/midi_alloc_pkg.sv
// Shared definitions for the MIDI voice allocator.
//  - state_t     : allocator FSM state encoding
//  - NOTE_ON / NOTE_OFF / CTRL : MIDI status nibbles (channel nibble ignored)
//  - CC_SUSTAIN / CC_ALL_OFF   : controller numbers acted upon
package midi_alloc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_SCAN,
    S_GAP,
    S_LOAD,
    S_RELEASE,
    S_ACK
  } state_t;

  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] CTRL     = 4'hB;

  localparam logic [6:0] CC_SUSTAIN = 7'h40;
  localparam logic [6:0] CC_ALL_OFF = 7'h7B;

endpackage

// File: rtl/voice_age_tracker.sv
// Per-voice saturating age counters for the voice allocator.
// Ports:
//  - clk, rst : clock, asynchronous active-high reset
//  - load     : one-cycle strobe, voice 'sel' is being (re)loaded
//  - sel      : index of the voice being loaded
//  - gate     : current per-voice gate vector
//  - oldest   : index of the gated voice with the largest age (ties -> lowest index)
// On load the selected voice restarts at age 0 and every other gated voice
// ages by one, saturating at all-ones.
module voice_age_tracker #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_BITS   = 8,
  localparam int IDX_W     = $clog2(NUM_VOICES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [IDX_W-1:0]      sel,
  input  logic [NUM_VOICES-1:0] gate,
  output logic [IDX_W-1:0]      oldest
);

  logic [AGE_BITS-1:0] age [NUM_VOICES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_VOICES; i++) age[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (IDX_W'(i) == sel)
          age[i] <= '0;
        else if (gate[i] && (age[i] != '1))
          age[i] <= age[i] + 1'b1;
      end
    end
  end

  // Strict '>' keeps the lowest index on ties.
  logic                found;
  logic [AGE_BITS-1:0] best;
  always_comb begin
    oldest = '0;
    best   = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (gate[i] && (!found || (age[i] > best))) begin
        found  = 1'b1;
        best   = age[i];
        oldest = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/midi_voice_allocator.sv
// Voice scheduler between the MIDI receiver and the voice bank.
// Takes framed MIDI events, assigns note-ons to voices (same-note retrigger,
// else a free voice, else steal the oldest) and drives the per-voice
// gate/note/frequency registers. A steal or retrigger of a sounding voice
// holds its gate low for RETRIG_CYCLES so the envelope sees a fresh edge.
// Ports:
//  - clk, rst                  : clock, asynchronous active-high reset
//  - midi_event_valid          : event available; held until midi_event_ack
//  - midi_command / _parameter_1 / _parameter_2 : status byte and data bytes
//  - midi_event_ack            : one-cycle pulse when the event is consumed
//  - lookup_note / lookup_freq : captured note out, its tone frequency back (combinational)
//  - voice_gate / voice_note / voice_frequency : packed per-voice registers
//  - busy                      : FSM not idle
// Handshake: an event is taken in IDLE when valid is high; upstream keeps
// valid and the fields stable until it sees the ack pulse, and must drop or
// change valid in the cycle after the ack.
// Optional build macro SUSTAIN_PEDAL_EN: CC 0x40 sustain pedal holds released
// voices until pedal-up.
module midi_voice_allocator
  import midi_alloc_pkg::*;
#(
  parameter int NUM_VOICES    = 4,
  parameter int FREQ_BITS     = 16,
  parameter int AGE_BITS      = 8,
  parameter int RETRIG_CYCLES = 128
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            midi_event_valid,
  input  logic [7:0]                      midi_command,
  input  logic [6:0]                      midi_parameter_1,
  input  logic [6:0]                      midi_parameter_2,
  output logic                            midi_event_ack,
  output logic [6:0]                      lookup_note,
  input  logic [FREQ_BITS-1:0]            lookup_freq,
  output logic [NUM_VOICES-1:0]           voice_gate,
  output logic [7*NUM_VOICES-1:0]         voice_note,
  output logic [FREQ_BITS*NUM_VOICES-1:0] voice_frequency,
  output logic                            busy
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int CNT_W = $clog2(RETRIG_CYCLES + 1);

  state_t                 state;
  logic [3:0]             status;
  logic [6:0]             velocity;
  logic [FREQ_BITS-1:0]   freq_q;
  logic [NUM_VOICES-1:0]  gate_r;
  logic [6:0]             note_r [NUM_VOICES];
  logic [FREQ_BITS-1:0]   freq_r [NUM_VOICES];
  logic [IDX_W-1:0]       scan_idx, sel, match_idx, free_idx, oldest;
  logic                   match_found, free_found;
  logic [CNT_W-1:0]       gap_cnt;
`ifdef SUSTAIN_PEDAL_EN
  logic                   pedal;
  logic [NUM_VOICES-1:0]  held;
`endif

  // MIDI channel is ignored (omni mode).
  logic unused_channel;
  assign unused_channel = ^midi_command[3:0];

  assign voice_gate = gate_r;
  assign busy       = (state != S_IDLE);

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign voice_note[7*g +: 7]                    = note_r[g];
    assign voice_frequency[FREQ_BITS*g +: FREQ_BITS] = freq_r[g];
  end

  voice_age_tracker #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_BITS   (AGE_BITS)
  ) u_age (
    .clk    (clk),
    .rst    (rst),
    .load   (state == S_LOAD),
    .sel    (sel),
    .gate   (gate_r),
    .oldest (oldest)
  );

  // Scan step: fold the voice at scan_idx into the running match/free results
  // so the final pick is available in the last scan cycle.
  logic             m_hit, f_hit, last_scan;
  logic [IDX_W-1:0] m_idx, f_idx, pick;
  always_comb begin
    m_hit     = match_found | (note_r[scan_idx] == lookup_note);
    m_idx     = match_found ? match_idx : scan_idx;
    f_hit     = free_found | !gate_r[scan_idx];
    f_idx     = free_found ? free_idx : scan_idx;
    last_scan = (scan_idx == IDX_W'(NUM_VOICES - 1));
    if (m_hit)      pick = m_idx;
    else if (f_hit) pick = f_idx;
    else            pick = oldest;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      status         <= '0;
      velocity       <= '0;
      lookup_note    <= '0;
      freq_q         <= '0;
      gate_r         <= '0;
      scan_idx       <= '0;
      sel            <= '0;
      match_idx      <= '0;
      free_idx       <= '0;
      match_found    <= 1'b0;
      free_found     <= 1'b0;
      gap_cnt        <= '0;
      midi_event_ack <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_r[i] <= '0;
        freq_r[i] <= '0;
      end
`ifdef SUSTAIN_PEDAL_EN
      pedal <= 1'b0;
      held  <= '0;
`endif
    end else begin
      midi_event_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (midi_event_valid && !midi_event_ack) begin
            status      <= midi_command[7:4];
            lookup_note <= midi_parameter_1;
            velocity    <= midi_parameter_2;
            state       <= S_DECODE;
          end
        end

        S_DECODE: begin
          freq_q <= lookup_freq;
          if (status == NOTE_ON && velocity != 7'd0) begin
            scan_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            state       <= S_SCAN;
          end else if (status == NOTE_OFF || status == NOTE_ON) begin
            state <= S_RELEASE;
          end else if (status == CTRL && lookup_note == CC_ALL_OFF) begin
            gate_r         <= '0;
`ifdef SUSTAIN_PEDAL_EN
            held           <= '0;
`endif
            midi_event_ack <= 1'b1;
            state          <= S_ACK;
`ifdef SUSTAIN_PEDAL_EN
          end else if (status == CTRL && lookup_note == CC_SUSTAIN) begin
            pedal <= velocity[6];
            if (!velocity[6]) begin
              gate_r <= gate_r & ~held;
              held   <= '0;
            end
            midi_event_ack <= 1'b1;
            state          <= S_ACK;
`endif
          end else begin
            midi_event_ack <= 1'b1;
            state          <= S_ACK;
          end
        end

        S_SCAN: begin
          match_found <= m_hit;
          match_idx   <= m_idx;
          free_found  <= f_hit;
          free_idx    <= f_idx;
          scan_idx    <= scan_idx + 1'b1;
          if (last_scan) begin
            sel     <= pick;
            gap_cnt <= '0;
            state   <= gate_r[pick] ? S_GAP : S_LOAD;
          end
        end

        S_GAP: begin
          gate_r[sel] <= 1'b0;
          gap_cnt     <= gap_cnt + 1'b1;
          if (gap_cnt == CNT_W'(RETRIG_CYCLES - 1)) state <= S_LOAD;
        end

        S_LOAD: begin
          gate_r[sel]    <= 1'b1;
          note_r[sel]    <= lookup_note;
          freq_r[sel]    <= freq_q;
`ifdef SUSTAIN_PEDAL_EN
          held[sel]      <= 1'b0;
`endif
          midi_event_ack <= 1'b1;
          state          <= S_ACK;
        end

        S_RELEASE: begin
          // Note and freq stay so the release tail keeps its pitch.
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (gate_r[i] && note_r[i] == lookup_note) begin
`ifdef SUSTAIN_PEDAL_EN
              if (pedal) held[i]   <= 1'b1;
              else       gate_r[i] <= 1'b0;
`else
              gate_r[i] <= 1'b0;
`endif
            end
          end
          midi_event_ack <= 1'b1;
          state          <= S_ACK;
        end

        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
